gpu_frame_tx: RTL and testbench

Transmit side of the GPU's 16-bit data-frame interface, mirroring the frame input used for program loading. The GPU core fills a local frame buffer, then issues a start command with a length. The block streams a header word, the buffered words and an XOR checksum over a valid/ready word link, and raises frame_being_sent for the whole transfer. It sits at the GPU output boundary, feeding the host or test harness.

---
 rtl/gpu_frame_pkg.sv | 16 +
 rtl/gpu_frame_buf.sv | 28 ++
 rtl/gpu_frame_tx.sv | 152 +++++++++++++++
 tb/tb_gpu_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_frame_pkg.sv
// Shared definitions for the GPU frame transmit path: word width, default
// buffer depth and the transmit FSM state encoding.
package gpu_frame_pkg;

  localparam int FRAME_W            = 16;
  localparam int DEFAULT_DATA_DEPTH = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/gpu_frame_buf.sv
// Frame buffer: one write port, one asynchronous read port, DATA_DEPTH x 16.
// Writes are suppressed while i_wr_block is high; contents survive reset.
module gpu_frame_buf
  import gpu_frame_pkg::*;
#(
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  parameter int AW         = $clog2(DATA_DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic               i_wr_block,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [FRAME_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [FRAME_W-1:0] o_rd_data
);

  logic [FRAME_W-1:0] r_mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_wr_block) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gpu_frame_tx.sv
// GPU frame transmitter: streams header (length), buffered words and an XOR
// checksum over a valid/ready link, one word per cycle when not stalled.
module gpu_frame_tx
  import gpu_frame_pkg::*;
#(
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  parameter int LEN_W      = $clog2(DATA_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(DATA_DEPTH)-1:0] wr_addr,
  input  logic [FRAME_W-1:0]            wr_data,
  input  logic                          start,
  input  logic [LEN_W-1:0]              frame_len,
  output logic [FRAME_W-1:0]            out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_being_sent,
  output logic                          done,
  output logic                          err,
  output state_t                        dbg_state
);

  localparam int AW = $clog2(DATA_DEPTH);

  state_t             r_state, w_state_n;
  logic [LEN_W-1:0]   r_len, w_len_n;
  logic [AW-1:0]      r_idx, w_idx_n, w_rd_addr;
  logic [FRAME_W-1:0] r_csum, w_csum_n, w_csum_hs;
  logic [FRAME_W-1:0] r_out_data, w_out_data_n, w_rd_data;
  logic               r_out_valid, w_out_valid_n;
  logic               r_done, w_done_n;
  logic               r_err, w_err_n;
  logic               w_hs, w_busy, w_len_ok, w_last;

  // Link contract: a word moves on a rising edge where out_valid & out_ready;
  // out_data/out_valid are registers and only change after such a transfer.
  assign w_hs      = r_out_valid & out_ready;
  assign w_busy    = (r_state == S_HEADER) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign w_len_ok  = (frame_len != '0) && (frame_len <= LEN_W'(DATA_DEPTH));
  assign w_last    = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
  assign w_csum_hs = r_csum ^ r_out_data;

  // Read one word ahead so the next word is ready to register on a handshake.
  assign w_rd_addr = (r_state == S_DATA) ? (r_idx + AW'(1)) : '0;

  gpu_frame_buf #(
    .DATA_DEPTH (DATA_DEPTH),
    .AW         (AW)
  ) u_buf (
    .clk        (clk),
    .i_wr_en    (wr_en),
    .i_wr_block (w_busy),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_addr  (w_rd_addr),
    .o_rd_data  (w_rd_data)
  );

  always_comb begin
    w_state_n     = r_state;
    w_len_n       = r_len;
    w_idx_n       = r_idx;
    w_csum_n      = r_csum;
    w_out_data_n  = r_out_data;
    w_out_valid_n = r_out_valid;
    w_done_n      = 1'b0;
    w_err_n       = wr_en & w_busy;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_len_n       = frame_len;
            w_csum_n      = '0;
            w_idx_n       = '0;
            w_out_data_n  = FRAME_W'(frame_len);
            w_out_valid_n = 1'b1;
            w_state_n     = S_HEADER;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (w_hs) begin
          w_csum_n     = w_csum_hs;
          w_idx_n      = '0;
          w_out_data_n = w_rd_data;
          w_state_n    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          w_csum_n = w_csum_hs;
          if (w_last) begin
            w_out_data_n = w_csum_hs;
            w_state_n    = S_CHECK;
          end else begin
            w_idx_n      = r_idx + AW'(1);
            w_out_data_n = w_rd_data;
          end
        end
      end
      S_CHECK: begin
        if (w_hs) begin
          w_out_valid_n = 1'b0;
          w_out_data_n  = '0;
          w_done_n      = 1'b1;
          w_state_n     = S_DONE;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n     = S_IDLE;
        w_out_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_len       <= w_len_n;
      r_idx       <= w_idx_n;
      r_csum      <= w_csum_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
      r_done      <= w_done_n;
      r_err       <= w_err_n;
    end
  end

  assign out_data         = r_out_data;
  assign out_valid        = r_out_valid;
  assign frame_being_sent = w_busy;
  assign done             = r_done;
  assign err              = r_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_gpu_frame_tx.sv
// Bench for gpu_frame_tx: frame expectations are queued at start time from a
// memory model; a negedge monitor pops and compares every accepted word.
module tb_gpu_frame_tx;
  import gpu_frame_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LW    = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic [LW-1:0] frame_len;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          frame_being_sent;
  logic          done;
  logic          err;
  state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem_model [DEPTH];

  int          ready_mode = 0;
  int          pat_cnt    = 0;
  logic        stall_pending = 1'b0;
  logic [15:0] stall_data;

  gpu_frame_tx dut (
    .clk              (clk),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .start            (start),
    .frame_len        (frame_len),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .frame_being_sent (frame_being_sent),
    .done             (done),
    .err              (err),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // downstream ready generator: 0 = always ready, 1 = random, 2 = 1,0,0 repeating
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (pat_cnt % 3 == 0);
        pat_cnt++;
      end
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending)
        check("stall_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, stall_data});
      check("fbs_vs_valid", {31'd0, frame_being_sent}, {31'd0, out_valid});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          check("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
      end
      stall_pending = out_valid && !out_ready;
      stall_data    = out_data;
    end
  end

  // reference model: a frame is len, buffer[0..len-1], then XOR of all of them
  function automatic void push_frame(input int len);
    logic [15:0] cs;
    logic [31:0] l32;
    l32 = len;
    cs  = l32[15:0];
    exp_q.push_back(cs);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem_model[i]);
      cs = cs ^ mem_model[i];
    end
    exp_q.push_back(cs);
  endfunction

  // driver tasks
  task automatic write_word(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    mem_model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send_start(input int len);
    start     = 1'b1;
    frame_len = LW'(len);
    tick();
    start = 1'b0;
    check("latency_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_state(input state_t s);
    int n;
    n = 0;
    while (dbg_state != s && n < 5000) begin
      tick();
      n++;
    end
    check("reach_state", {29'd0, dbg_state}, {29'd0, s});
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done after %0d cycles, need 1", name, n);
      exp_q.delete();
    end else begin
      if (exp_cycles > 0) check({name, "_cycles"}, n, exp_cycles);
      check({name, "_drained"}, exp_q.size(), 0);
      tick();
      check({name, "_done_1cyc"}, {31'd0, done}, 32'd0);
      check({name, "_idle"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    end
  endtask

  task automatic bad_start(input string name, input int len);
    start     = 1'b1;
    frame_len = LW'(len);
    tick();
    start = 1'b0;
    check({name, "_err"}, {31'd0, err}, 32'd1);
    check({name, "_novalid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_idle"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    tick();
    check({name, "_err_clr"}, {31'd0, err}, 32'd0);
    check({name, "_novalid2"}, {31'd0, out_valid}, 32'd0);
  endtask

  int          rlen;
  logic [15:0] rd;

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    frame_len = '0;
    #12;
    check("reset_outputs", {12'd0, out_valid, frame_being_sent, done, err, out_data},
          32'd0);
    check("reset_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // directed 3-word frame, no stalls: 5 handshakes back to back
    write_word(0, 16'h1111);
    write_word(1, 16'h2222);
    write_word(2, 16'h4444);
    ready_mode = 0;
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h7774);
    send_start(3);
    wait_done("len3", 5);

    // same frame with ready pattern 1,0,0,...
    ready_mode = 2;
    pat_cnt    = 0;
    push_frame(3);
    send_start(3);
    wait_done("len3_stall", -1);

    // illegal lengths
    ready_mode = 0;
    bad_start("len0", 0);
    bad_start("len1025", 1025);

    // write during DATA is dropped and flagged; frame unaffected
    ready_mode = 2;
    push_frame(3);
    send_start(3);
    wait_state(S_DATA);
    wr_en   = 1'b1;
    wr_addr = AW'(1);
    wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    check("busy_wr_err", {31'd0, err}, 32'd1);
    wait_done("busy_wr", -1);
    ready_mode = 0;
    push_frame(3);
    send_start(3);
    wait_done("busy_wr_after", 5);

    // asynchronous reset in the middle of a 5-word frame
    for (int i = 0; i < 5; i++) write_word(i, 16'($urandom));
    ready_mode = 1;
    push_frame(5);
    send_start(5);
    wait_state(S_DATA);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outputs", {28'd0, out_valid, frame_being_sent, done, err}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("midreset_nodone", {31'd0, done}, 32'd0);
    push_frame(1);
    send_start(1);
    wait_done("after_reset", -1);

    // write and start in the same cycle: the frame sees the new word
    ready_mode = 0;
    rd = 16'($urandom);
    wr_en     = 1'b1;
    wr_addr   = '0;
    wr_data   = rd;
    mem_model[0] = rd;
    push_frame(1);
    send_start(1);
    wr_en = 1'b0;
    wait_done("wr_and_start", 3);

    // random frames, random back-pressure
    for (int f = 0; f < 6; f++) begin
      rlen = $urandom_range(1, 40);
      for (int i = 0; i < rlen; i++) write_word(i, 16'($urandom));
      ready_mode = 1;
      push_frame(rlen);
      send_start(rlen);
      wait_done("rand", -1);
    end

    // full-depth frame, buffer[i] = i
    ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'(i));
    push_frame(DEPTH);
    check("full_header_model", {16'd0, exp_q[0]}, 32'h0400);
    check("full_csum_model", {16'd0, exp_q[exp_q.size()-1]}, 32'h0400);
    send_start(DEPTH);
    wait_done("full", DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
